// File: rtl/seg7_scan_2421_pkg.sv
// Shared 2421 code points, active-low 7-segment glyphs and code validity helper
// for the multiplexed display driver.
package seg2421_pkg;

   localparam logic [3:0] CODE_0 = 4'b0000;
   localparam logic [3:0] CODE_1 = 4'b0001;
   localparam logic [3:0] CODE_2 = 4'b0010;
   localparam logic [3:0] CODE_3 = 4'b0011;
   localparam logic [3:0] CODE_4 = 4'b0100;
   localparam logic [3:0] CODE_5 = 4'b1011;
   localparam logic [3:0] CODE_6 = 4'b1100;
   localparam logic [3:0] CODE_7 = 4'b1101;
   localparam logic [3:0] CODE_8 = 4'b1110;
   localparam logic [3:0] CODE_9 = 4'b1111;

   // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
   localparam logic [6:0] SEG_0    = 7'b1000000;
   localparam logic [6:0] SEG_1    = 7'b1111001;
   localparam logic [6:0] SEG_2    = 7'b0100100;
   localparam logic [6:0] SEG_3    = 7'b0110000;
   localparam logic [6:0] SEG_4    = 7'b0011001;
   localparam logic [6:0] SEG_5    = 7'b0010010;
   localparam logic [6:0] SEG_6    = 7'b0000010;
   localparam logic [6:0] SEG_7    = 7'b1111000;
   localparam logic [6:0] SEG_8    = 7'b0000000;
   localparam logic [6:0] SEG_9    = 7'b0010000;
   localparam logic [6:0] SEG_DASH = 7'b0111111;
   localparam logic [6:0] SEG_OFF  = 7'b1111111;

   typedef struct packed {
      logic [6:0] seg_n;
      logic       dp_n;
      logic       dash;
   } disp_t;

   function automatic logic is_valid_2421(input logic [3:0] code);
      logic ok;
      case (code)
         CODE_0, CODE_1, CODE_2, CODE_3, CODE_4,
         CODE_5, CODE_6, CODE_7, CODE_8, CODE_9: ok = 1'b1;
         default:                                ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/seg7_scan_2421_dec.sv
// Combinational 2421 code to active-low 7-segment decoder; invalid codes
// render as a dash and drop the valid flag.
module dec_2421_to_seg7
   import seg2421_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] seg_n,
   output logic       valid
);

   // Glyph lookup with a dash for every unused code point
   always_comb begin
      seg_n = SEG_DASH;
      valid = is_valid_2421(code);
      case (code)
         CODE_0:  seg_n = SEG_0;
         CODE_1:  seg_n = SEG_1;
         CODE_2:  seg_n = SEG_2;
         CODE_3:  seg_n = SEG_3;
         CODE_4:  seg_n = SEG_4;
         CODE_5:  seg_n = SEG_5;
         CODE_6:  seg_n = SEG_6;
         CODE_7:  seg_n = SEG_7;
         CODE_8:  seg_n = SEG_8;
         CODE_9:  seg_n = SEG_9;
         default: seg_n = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg7_scan_2421.sv
// Time-multiplexed 7-segment driver for 2421 digits: frame-latched shadow,
// leading-zero blanking and a sticky invalid-code flag.
module seg7_scan_2421
   import seg2421_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 50000
)
(
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    blank_lz,
   input  logic                    err_clr,
   output logic [6:0]              seg_n,
   output logic                    dp_n,
   output logic [NUM_DIGITS-1:0]   an_n,
   output logic                    code_err
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic [CNT_W-1:0]        cnt_r;
   logic [IDX_W-1:0]        idx_r;
   logic [4*NUM_DIGITS-1:0] shadow_dig_r;
   logic [NUM_DIGITS-1:0]   shadow_dp_r;
   logic [6:0]              seg_n_r;
   logic                    dp_n_r;
   logic [NUM_DIGITS-1:0]   an_n_r;
   logic                    dash_r;
   logic                    code_err_r;

   logic                    tc_s;
   logic                    frame_end_s;
   logic [NUM_DIGITS-1:0]   sel_s;
   logic [NUM_DIGITS-1:0]   upper_zero_s;
   logic [3:0]              cur_code_s;
   logic                    cur_dp_s;
   logic                    cur_upper_zero_s;
   logic                    blank_s;
   logic [6:0]              dec_seg_s;
   logic                    dec_valid_s;
   disp_t                   disp_s;

   assign tc_s        = (cnt_r == CNT_LAST);
   assign frame_end_s = tc_s && (idx_r == IDX_LAST);

   // One-hot select of the driven digit and a suffix-zero chain from the top digit down
   always_comb begin
      sel_s        = {NUM_DIGITS{1'b0}};
      upper_zero_s = {NUM_DIGITS{1'b0}};
      for (int k = 0; k < NUM_DIGITS; k++) begin
         sel_s[k] = (idx_r == IDX_W'(k));
      end
      upper_zero_s[NUM_DIGITS-1] = (shadow_dig_r[4*(NUM_DIGITS-1) +: 4] == CODE_0);
      for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
         upper_zero_s[k] = upper_zero_s[k+1] && (shadow_dig_r[4*k +: 4] == CODE_0);
      end
   end

   // AND-OR mux of the shadow digit, its dp bit and its blanking qualifier
   always_comb begin
      cur_code_s       = 4'b0000;
      cur_dp_s         = 1'b0;
      cur_upper_zero_s = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         cur_code_s       = cur_code_s | (shadow_dig_r[4*k +: 4] & {4{sel_s[k]}});
         cur_dp_s         = cur_dp_s | (shadow_dp_r[k] & sel_s[k]);
         cur_upper_zero_s = cur_upper_zero_s | (upper_zero_s[k] & sel_s[k]);
      end
   end

   dec_2421_to_seg7 u_dec (
      .code  (cur_code_s),
      .seg_n (dec_seg_s),
      .valid (dec_valid_s)
   );

   // Digit 0 is never blanked; an invalid code never compares equal to zero
   assign blank_s = blank_lz && (idx_r != {IDX_W{1'b0}}) && cur_upper_zero_s;

   // Next display word for the digit currently selected by idx_r
   always_comb begin
      disp_s.dp_n = ~cur_dp_s;
      if (blank_s) begin
         disp_s.seg_n = SEG_OFF;
         disp_s.dash  = 1'b0;
      end else begin
         disp_s.seg_n = dec_seg_s;
         disp_s.dash  = ~dec_valid_s;
      end
   end

   // Dwell prescaler and digit index
   always_ff @(posedge CLK) begin
      if (RESET) begin
         cnt_r <= {CNT_W{1'b0}};
         idx_r <= {IDX_W{1'b0}};
      end else if (tc_s) begin
         cnt_r <= {CNT_W{1'b0}};
         idx_r <= (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
      end else begin
         cnt_r <= cnt_r + CNT_W'(1);
         idx_r <= idx_r;
      end
   end

   // Shadow capture only on the last cycle of a frame, so the display never tears
   always_ff @(posedge CLK) begin
      if (RESET) begin
         shadow_dig_r <= {(4*NUM_DIGITS){1'b0}};
         shadow_dp_r  <= {NUM_DIGITS{1'b0}};
      end else if (frame_end_s) begin
         shadow_dig_r <= digits_in;
         shadow_dp_r  <= dp_in;
      end else begin
         shadow_dig_r <= shadow_dig_r;
         shadow_dp_r  <= shadow_dp_r;
      end
   end

   // Registered display outputs, one cycle behind idx_r
   always_ff @(posedge CLK) begin
      if (RESET) begin
         seg_n_r <= SEG_OFF;
         dp_n_r  <= 1'b1;
         an_n_r  <= {NUM_DIGITS{1'b1}};
         dash_r  <= 1'b0;
      end else begin
         seg_n_r <= disp_s.seg_n;
         dp_n_r  <= disp_s.dp_n;
         an_n_r  <= ~sel_s;
         dash_r  <= disp_s.dash;
      end
   end

   // Sticky error: a displayed dash sets it one edge later and outranks err_clr
   always_ff @(posedge CLK) begin
      if (RESET) begin
         code_err_r <= 1'b0;
      end else begin
         code_err_r <= dash_r | (code_err_r & ~err_clr);
      end
   end

   assign seg_n    = seg_n_r;
   assign dp_n     = dp_n_r;
   assign an_n     = an_n_r;
   assign code_err = code_err_r;

endmodule

// File: tb/tb_seg7_scan_2421.sv
// Directed bench for seg7_scan_2421 with NUM_DIGITS=4, SCAN_DIV=4.
module tb_seg7_scan_2421;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [15:0] digits_in;
   logic [3:0]  dp_in;
   logic        blank_lz;
   logic        err_clr;
   logic [6:0]  seg_n;
   logic        dp_n;
   logic [3:0]  an_n;
   logic        code_err;

   int checks   = 0;
   int failures = 0;

   seg7_scan_2421 #(.NUM_DIGITS(4), .SCAN_DIV(4)) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .digits_in (digits_in),
      .dp_in     (dp_in),
      .blank_lz  (blank_lz),
      .err_clr   (err_clr),
      .seg_n     (seg_n),
      .dp_n      (dp_n),
      .an_n      (an_n),
      .code_err  (code_err)
   );

   always #5 CLK = ~CLK;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   // Leaves the bench on the first cycle digit 0 of a freshly latched frame is shown.
   task automatic goto_frame_start;
      int b;
      b = 0;
      while (an_n !== 4'b1011 && b < 100) begin tick(1); b++; end
      while (an_n !== 4'b0111 && b < 100) begin tick(1); b++; end
      while (an_n !== 4'b1110 && b < 100) begin tick(1); b++; end
      checks++;
      if (b >= 100) begin
         failures++;
         $display("FAIL frame_sync timeout an_n=%b wanted 1110", an_n);
      end
   endtask

   task automatic test_reset;
      RESET = 1'b1; digits_in = 16'h0000; dp_in = 4'b0000;
      blank_lz = 1'b0; err_clr = 1'b0;
      tick(3);
      checks++;
      if ({seg_n, dp_n, an_n, code_err} !== {7'h7F, 1'b1, 4'b1111, 1'b0}) begin
         failures++;
         $display("FAIL reset_state got seg=%b dp=%b an=%b err=%b", seg_n, dp_n, an_n, code_err);
      end
      RESET = 1'b0;
      tick(1);
      checks++;
      if ({an_n, seg_n, dp_n} !== {4'b1110, 7'b1000000, 1'b1}) begin
         failures++;
         $display("FAIL reset_release got an=%b seg=%b dp=%b exp an=1110 seg=1000000 dp=1", an_n, seg_n, dp_n);
      end
   endtask

   task automatic test_scan_order;
      logic [3:0] one;
      logic [3:0] exp_an;
      one = 4'b0001;
      goto_frame_start();
      for (int i = 0; i < 32; i++) begin
         exp_an = ~(one << ((i / 4) % 4));
         checks++;
         if (an_n !== exp_an) begin
            failures++;
            $display("FAIL scan_order cyc=%0d got an=%b exp %b", i, an_n, exp_an);
         end
         tick(1);
      end
   endtask

   task automatic test_decode;
      logic [6:0] exp_seg [4];
      logic [3:0] one;
      logic [3:0] dpv;
      one = 4'b0001;
      dpv = 4'b0010;
      exp_seg[0] = 7'b1111001;
      exp_seg[1] = 7'b0011001;
      exp_seg[2] = 7'b0010010;
      exp_seg[3] = 7'b0010000;
      digits_in = 16'hFB41; dp_in = dpv;
      goto_frame_start();
      for (int k = 0; k < 4; k++) begin
         checks++;
         if ({an_n, seg_n, dp_n} !== {~(one << k), exp_seg[k], ~dpv[k]}) begin
            failures++;
            $display("FAIL decode digit%0d got an=%b seg=%b dp=%b exp seg=%b dp=%b", k, an_n, seg_n, dp_n, exp_seg[k], ~dpv[k]);
         end
         tick(4);
      end
      dp_in = 4'b0000;
   endtask

   task automatic test_invalid_code;
      digits_in = 16'h0050;
      goto_frame_start();
      tick(4);
      checks++;
      if ({an_n, seg_n, code_err} !== {4'b1101, 7'b0111111, 1'b0}) begin
         failures++;
         $display("FAIL invalid_dash got an=%b seg=%b err=%b exp an=1101 seg=0111111 err=0", an_n, seg_n, code_err);
      end
      tick(1);
      checks++;
      if (code_err !== 1'b1) begin
         failures++;
         $display("FAIL invalid_err_set got %b exp 1", code_err);
      end
      digits_in = 16'h0000;
      goto_frame_start();
      checks++;
      if (code_err !== 1'b1) begin
         failures++;
         $display("FAIL err_sticky got %b exp 1", code_err);
      end
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      checks++;
      if (code_err !== 1'b0) begin
         failures++;
         $display("FAIL err_clear got %b exp 0", code_err);
      end
      digits_in = 16'h0050;
      err_clr = 1'b1;
      goto_frame_start();
      tick(5);
      checks++;
      if ({an_n, code_err} !== {4'b1101, 1'b1}) begin
         failures++;
         $display("FAIL set_beats_clear got an=%b err=%b exp an=1101 err=1", an_n, code_err);
      end
      tick(2);
      checks++;
      if (code_err !== 1'b1) begin
         failures++;
         $display("FAIL set_beats_clear_hold got %b exp 1", code_err);
      end
      err_clr = 1'b0;
      digits_in = 16'h0000;
   endtask

   task automatic test_blanking;
      logic [6:0] exp_on  [4];
      logic [6:0] exp_off [4];
      logic [3:0] dpv;
      dpv = 4'b0100;
      exp_on[0]  = 7'b1000000; exp_on[1]  = 7'b0110000;
      exp_on[2]  = 7'h7F;      exp_on[3]  = 7'h7F;
      exp_off[0] = 7'b1000000; exp_off[1] = 7'b0110000;
      exp_off[2] = 7'b1000000; exp_off[3] = 7'b1000000;
      digits_in = 16'h0030; dp_in = dpv; blank_lz = 1'b1;
      goto_frame_start();
      for (int k = 0; k < 4; k++) begin
         checks++;
         if ({seg_n, dp_n} !== {exp_on[k], ~dpv[k]}) begin
            failures++;
            $display("FAIL blank_on digit%0d got seg=%b dp=%b exp seg=%b dp=%b", k, seg_n, dp_n, exp_on[k], ~dpv[k]);
         end
         tick(4);
      end
      blank_lz = 1'b0;
      goto_frame_start();
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (seg_n !== exp_off[k]) begin
            failures++;
            $display("FAIL blank_off digit%0d got seg=%b exp %b", k, seg_n, exp_off[k]);
         end
         tick(4);
      end
      dp_in = 4'b0000;
   endtask

   task automatic test_tear_and_reset;
      digits_in = 16'h4321;
      goto_frame_start();
      tick(4);
      digits_in = 16'hFFFF;
      checks++;
      if (seg_n !== 7'b0100100) begin
         failures++;
         $display("FAIL tear_d1 got %b exp 0100100", seg_n);
      end
      tick(4);
      checks++;
      if (seg_n !== 7'b0110000) begin
         failures++;
         $display("FAIL tear_d2 got %b exp 0110000", seg_n);
      end
      tick(4);
      checks++;
      if (seg_n !== 7'b0011001) begin
         failures++;
         $display("FAIL tear_d3 got %b exp 0011001", seg_n);
      end
      tick(4);
      checks++;
      if ({an_n, seg_n} !== {4'b1110, 7'b0010000}) begin
         failures++;
         $display("FAIL tear_next_frame got an=%b seg=%b exp an=1110 seg=0010000", an_n, seg_n);
      end
      digits_in = 16'h0600;
      goto_frame_start();
      tick(9);
      checks++;
      if ({an_n, code_err} !== {4'b1011, 1'b1}) begin
         failures++;
         $display("FAIL pre_reset got an=%b err=%b exp an=1011 err=1", an_n, code_err);
      end
      RESET = 1'b1;
      tick(1);
      checks++;
      if ({seg_n, dp_n, an_n, code_err} !== {7'h7F, 1'b1, 4'b1111, 1'b0}) begin
         failures++;
         $display("FAIL mid_reset got seg=%b dp=%b an=%b err=%b", seg_n, dp_n, an_n, code_err);
      end
      RESET = 1'b0;
      tick(1);
      checks++;
      if ({an_n, seg_n, code_err} !== {4'b1110, 7'b1000000, 1'b0}) begin
         failures++;
         $display("FAIL restart got an=%b seg=%b err=%b exp an=1110 seg=1000000 err=0", an_n, seg_n, code_err);
      end
   endtask

   initial begin
      test_reset();
      test_scan_order();
      test_decode();
      test_invalid_code();
      test_blanking();
      test_tear_and_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
